// File: rtl/uart_tx_frame_if.sv
// FIFO read handshake between the transmit FIFO and the UART framer.
// The framer is the master: it issues the read strobe and consumes the word.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 empty;
  logic                 read_enable;
  logic                 data_valid;

  modport master (output read_enable, input data_in, empty, data_valid);
  modport slave  (input read_enable, output data_in, empty, data_valid);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: fetches one word from a 1-cycle-latency FIFO and sends it as
// start / DATA_BITS LSB-first / optional parity / STOP_BITS stop, all outputs registered.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_frame_if.master    fifo,
  output logic               tx,
  output logic               busy,
  output logic               tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD = (PARITY_MODE == 1);

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bidx;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par;
  logic                 rd_en;

  assign fifo.read_enable = rd_en;

  wire last = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      bidx     <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par      <= 1'b0;
      rd_en    <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      rd_en   <= 1'b0;
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo.empty) begin
            rd_en <= 1'b1;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          // The strobe cycle itself belongs to IDLE; data_valid there is stray.
          if (fifo.data_valid && !rd_en) begin
            shreg <= fifo.data_in;
            par   <= (^fifo.data_in) ^ ODD;
            tx    <= 1'b0;
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (last) begin
            cnt   <= '0;
            bidx  <= '0;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (last) begin
            cnt <= '0;
            if (bidx == BIT_LAST) begin
              stop_cnt <= 1'b0;
              if (PARITY_MODE != 0) begin
                tx    <= par;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bidx  <= bidx + 1'b1;
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (last) begin
            cnt      <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (last) begin
            cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              tx_done <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7N2) at 4 clocks/bit,
// expected line levels queued per cycle when a word is handed over, then popped and compared.
module tb_uart_tx_frame;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       empty_v [4];
  logic       dv_v    [4];
  logic [8:0] din_v   [4];
  logic [3:0] tx_w, busy_w, done_w, re_w;
  logic       exp_q [$];

  uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if1 ();
  uart_tx_frame_if #(.DATA_BITS(8)) if2 ();
  uart_tx_frame_if #(.DATA_BITS(7)) if3 ();

  assign if0.empty = empty_v[0]; assign if0.data_valid = dv_v[0]; assign if0.data_in = din_v[0][7:0];
  assign if1.empty = empty_v[1]; assign if1.data_valid = dv_v[1]; assign if1.data_in = din_v[1][7:0];
  assign if2.empty = empty_v[2]; assign if2.data_valid = dv_v[2]; assign if2.data_in = din_v[2][7:0];
  assign if3.empty = empty_v[3]; assign if3.data_valid = dv_v[3]; assign if3.data_in = din_v[3][6:0];
  assign re_w = {if3.read_enable, if2.read_enable, if1.read_enable, if0.read_enable};

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset(reset), .fifo(if0.master), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .fifo(if1.master), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset(reset), .fifo(if2.master), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset(reset), .fifo(if3.master), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Per-cycle line levels for one frame of the selected configuration.
  function automatic void push_frame(input int sel, input logic [8:0] d);
    int   db = (sel == 3) ? 7 : 8;
    int   pm = (sel == 1) ? 2 : (sel == 2) ? 1 : 0;
    int   sb = (sel == 3) ? 2 : 1;
    logic p  = 1'b0;
    repeat (CPB) exp_q.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      p = p ^ d[i];
      repeat (CPB) exp_q.push_back(d[i]);
    end
    if (pm != 0) begin
      if (pm == 1) p = ~p;
      repeat (CPB) exp_q.push_back(p);
    end
    repeat (sb * CPB) exp_q.push_back(1'b1);
  endfunction

  // One frame: read strobe, FIFO answers `lat` cycles later, then every line cycle checked.
  task automatic frame(input int sel, input logic [8:0] d, input int lat,
                       input bit chained, input bit more);
    int n;
    if (!chained) begin
      empty_v[sel] = 1'b0;
      n = 0;
      do begin step(); n++; end while (!re_w[sel] && n < 20);
    end
    chk("read_enable", re_w[sel], 1);
    chk("busy_at_read", busy_w[sel], 1);
    empty_v[sel] = more ? 1'b0 : 1'b1;
    for (int i = 1; i < lat; i++) begin
      step();
      chk("fetch_re_low", re_w[sel], 0);
      chk("fetch_tx_idle", tx_w[sel], 1);
    end
    step();
    chk("pre_start_tx", tx_w[sel], 1);
    dv_v[sel]  = 1'b1;
    din_v[sel] = d;
    push_frame(sel, d);
    step();
    dv_v[sel]  = 1'b0;
    din_v[sel] = 9'($urandom);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk("tx_bit", tx_w[sel], exp_q.pop_front());
      chk("busy_frame", busy_w[sel], 1);
      chk("re_frame", re_w[sel], 0);
      chk("done_frame", done_w[sel], 0);
      step();
    end
    chk("tx_done", done_w[sel], 1);
    chk("busy_clear", busy_w[sel], 0);
    chk("tx_done_line", tx_w[sel], 1);
    if (more) step();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      empty_v[i] = 1'b1; dv_v[i] = 1'b0; din_v[i] = '0;
    end
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", tx_w[i], 1);
      chk("rst_busy", busy_w[i], 0);
      chk("rst_re", re_w[i], 0);
      chk("rst_done", done_w[i], 0);
    end

    frame(0, 9'h0A5, 1, 0, 0);
    frame(1, 9'h0A5, 1, 0, 0);
    frame(2, 9'h0A5, 1, 0, 0);
    frame(2, 9'h07F, 1, 0, 0);
    frame(3, 9'h07F, 1, 0, 1);
    frame(3, 9'h055, 1, 1, 0);

    frame(0, 9'h000, 1, 0, 1);
    frame(0, 9'h0FF, 1, 1, 1);
    frame(0, 9'h03C, 1, 1, 0);

    // Reset in the middle of data bit 3.
    empty_v[0] = 1'b0;
    begin
      int n = 0;
      do begin step(); n++; end while (!re_w[0] && n < 20);
    end
    chk("rst_mid_re", re_w[0], 1);
    empty_v[0] = 1'b1;
    step();
    dv_v[0] = 1'b1; din_v[0] = 9'h0A5;
    step();
    dv_v[0] = 1'b0;
    repeat (CPB + 3 * CPB + 1) step();
    chk("rst_mid_bit3", tx_w[0], 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_tx", tx_w[0], 1);
    chk("rst_mid_busy", busy_w[0], 0);
    chk("rst_mid_re0", re_w[0], 0);
    chk("rst_mid_done", done_w[0], 0);
    repeat (10) step();
    chk("rst_idle_tx", tx_w[0], 1);
    chk("rst_idle_busy", busy_w[0], 0);
    chk("rst_idle_re", re_w[0], 0);

    frame(0, 9'h0C3, 5, 0, 0);

    step();
    dv_v[0] = 1'b1; din_v[0] = 9'h000;
    step();
    dv_v[0] = 1'b0;
    for (int i = 0; i < 3 * CPB; i++) begin
      step();
      chk("stray_tx", tx_w[0], 1);
      chk("stray_busy", busy_w[0], 0);
      chk("stray_re", re_w[0], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that pulls bytes from a first-word-fall-through-free (1-cycle read latency) FIFO and serialises them onto the Tx line. It sits between the transmit FIFO and the board UART pin. It generalises our fixed 8N1 transmitter with:

- configurable data width, parity mode, stop-bit count and baud divisor;
- exact per-bit timing;
- Busy and TxDone status outputs for the system controller.

## Interface

Parameters:
- CLKS_PER_BIT, default 868: clock cycles per serial bit. Must be ≥ 2.
- DATA_BITS, default 8: payload bits per frame, legal range 5–9.
- PARITY_MODE, default 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, default 1: stop bits per frame, 1 or 2.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
- Tx  output  1  serial line; idle high.
- DataIn  input  DATA_BITS  FIFO read data; valid only while DataValid = 1.
- Empty  input  1  FIFO empty flag.
- ReadEnable  output  1  single-cycle FIFO read strobe.
- DataValid  input  1  FIFO asserts this one or more cycles after ReadEnable, together with DataIn.
- Busy  output  1  high from the ReadEnable cycle through the end of the last stop bit.
- TxDone  output  1  one-cycle pulse in the cycle after the last stop bit ends.

## Operation

Reset values:
- Tx = 1, ReadEnable = 0, Busy = 0, TxDone = 0.
- State = IDLE; baud counter, bit index and shift register = 0.

States: IDLE, FETCH, START, DATA, PARITY, STOP.
- **IDLE**
  - Tx = 1.
  - If Empty = 0: assert ReadEnable for exactly one cycle, set Busy, go to FETCH.
  - DataValid is ignored in IDLE.
- **FETCH**
  - ReadEnable = 0.
  - Waits indefinitely for DataValid = 1.
  - On DataValid: latch DataIn into the shift register, compute parity, go to START. Tx drives 0 from the next cycle.
- **START**: Tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA**
  - Data is sent LSB first; each bit is held for CLKS_PER_BIT cycles.
  - After bit DATA_BITS−1: go to PARITY if PARITY_MODE ≠ 0, else go to STOP.
- **PARITY**
  - Bit value is the XOR of the payload; inverted for odd mode. The total count of ones, including the parity bit, is odd for odd mode and even for even mode.
  - Held for CLKS_PER_BIT cycles, then go to STOP.
- **STOP**
  - Tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - Then pulse TxDone, clear Busy, go to IDLE.

Arithmetic and width rules:
- Baud counter width is clog2(CLKS_PER_BIT). It counts 0 to CLKS_PER_BIT−1 and wraps to 0 on each bit boundary. Every bit is exactly CLKS_PER_BIT cycles; there is no extra cycle per bit.
- Bit index width is clog2(DATA_BITS+1).
- The stop-bit counter counts to STOP_BITS−1.

Boundary conditions:
- DataIn and Empty changing mid-frame have no effect; the frame uses only latched data.
- Empty = 0 on the TxDone cycle: the next ReadEnable is issued in the following IDLE cycle. There is no other idle gap.
- Reset asserted mid-frame:
  - next cycle Tx = 1 and all outputs return to their reset values;
  - the partial frame is abandoned;
  - a FIFO word already read but not yet sent is discarded.
- Reset has priority over every other event in the same cycle.
- DataValid asserted outside FETCH is ignored.

## Timing

Frame length in bit periods: N = 1 + DATA_BITS + (PARITY_MODE ≠ 0) + STOP_BITS.

Cycle sequence, with cycle 0 the first IDLE cycle that sees Empty = 0:
- Cycle 0: ReadEnable = 1.
- Cycle 1: FETCH.
- Cycle d: DataValid = 1, where d ≥ 1.
- Cycles d+1 to d+CLKS_PER_BIT: Tx = 0 (start bit).
- Last stop-bit cycle: d + N × CLKS_PER_BIT.
- TxDone: cycle d + N × CLKS_PER_BIT + 1.

Output registering: Tx, ReadEnable, Busy and TxDone are all registered outputs. Tx has no combinational path from any input.

Back-to-back throughput with a 1-cycle-latency FIFO: one frame per N × CLKS_PER_BIT + 3 cycles.

## Test plan

All scenarios use CLKS_PER_BIT = 4 unless noted.
- **8N1, 0xA5**
  - Stimulus: FIFO holds 0xA5, DataValid 1 cycle after ReadEnable.
  - Required Tx: 0 ×4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 ×4.
  - TxDone pulses once at cycle 42; Busy is high cycles 0–41.
- **8E1 and 8O1, 0xA5** (four ones): parity bit is 0 for even mode and 1 for odd mode. Frame is 44 cycles after DataValid.
- **7N2, 0x7F**: start bit, then seven 1s, then 8 cycles high. The next ReadEnable does not occur before TxDone.
- **Back-to-back, FIFO holds 0x00, 0xFF, 0x3C**
  - Three frames, each ReadEnable issued in the cycle after the previous TxDone.
  - Tx never shows a spurious low outside the start and data bits.
- **Reset mid-frame**: assert Reset during DATA bit 3 for 1 cycle. Next cycle Tx = 1, Busy = 0, ReadEnable = 0. With Empty = 1 the block stays idle.
- **Slow FIFO and stray DataValid**
  - DataValid arrives 5 cycles after ReadEnable: start bit begins the cycle after DataValid.
  - DataValid pulsed while in IDLE with Empty = 1: no frame is sent, Tx stays 1.
